axis_pkt_fifo: RTL

- Store-and-forward packet FIFO placed directly downstream of the packet trimmer on the 64-bit AXI-Stream datapath.
- Accepts beats freely and releases a packet to the consumer only after its TLAST beat has been written, so the consumer never stalls mid-packet.
- Decouples the trimmer's upstream backpressure from the downstream sink.
- Also guards against packets longer than the buffer.

---
 rtl/axis_pkg.sv | 19 +
 rtl/axis_pkt_fifo_ram.sv | 45 ++++
 rtl/axis_pkt_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default widths, the stored beat layout and
// the pointer-width helper used by the packet FIFO.
package axis_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } axis_beat_t;

  // One extra MSB lets equal-index pointers tell full from empty.
  function automatic int ptrWidth(input int depthLog2);
    return depthLog2 + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Beat storage for axis_pkt_fifo: synchronous write, TLAST fixup write, and an
// asynchronous read port.
module axis_pkt_fifo_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [KEEP_W-1:0] wr_keep_i,
  input  logic              wr_last_i,
  input  logic              fix_en_i,
  input  logic [ADDR_W-1:0] fix_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [KEEP_W-1:0] rd_keep_o,
  output logic              rd_last_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W+KEEP_W-1:0] payloadMem [DEPTH];
  logic                     lastMem    [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      payloadMem[wr_addr_i] <= {wr_data_i, wr_keep_i};
    end
  end

  // TLAST lives in its own array so a force-commit can rewrite it alone.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      lastMem[wr_addr_i] <= wr_last_i;
    end else if (fix_en_i) begin
      lastMem[fix_addr_i] <= 1'b1;
    end
  end

  assign {rd_data_o, rd_keep_o} = payloadMem[rd_addr_i];
  assign rd_last_o              = lastMem[rd_addr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO with oversize-packet force-split.
// Define AXIS_PKT_FIFO_STATS_EN to add input/output packet counters.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int TDATA_W    = AXIS_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TDATA_W-1:0]   S0_AXIS_TDATA,
  input  logic [TDATA_W/8-1:0] S0_AXIS_TKEEP,
  input  logic                 S0_AXIS_TLAST,
  input  logic                 S0_AXIS_TVALID,
  output logic                 S0_AXIS_TREADY,
  output logic [TDATA_W-1:0]   M0_AXIS_TDATA,
  output logic [TDATA_W/8-1:0] M0_AXIS_TKEEP,
  output logic                 M0_AXIS_TLAST,
  output logic                 M0_AXIS_TVALID,
  input  logic                 M0_AXIS_TREADY,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 trunc_err
`ifdef AXIS_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]          stat_pkts_in,
  output logic [31:0]          stat_pkts_out
`endif
);

  localparam int PW = ptrWidth(DEPTH_LOG2);
  localparam logic [PW-1:0] DEPTH_P = PW'(1 << DEPTH_LOG2);

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] commitPtr_q, commitPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] level_q, level_d;
  logic          truncErr_q, truncErr_d;

  logic full, wrEn, rdEn, forceCommit;
  logic [DEPTH_LOG2-1:0] fixAddr;

  assign full        = (wrPtr_q - rdPtr_q) == DEPTH_P;
  assign wrEn        = S0_AXIS_TVALID && !full;
  assign rdEn        = M0_AXIS_TVALID && M0_AXIS_TREADY;
  assign forceCommit = full && (commitPtr_q == rdPtr_q);
  assign fixAddr     = wrPtr_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);

  // A full, wholly uncommitted buffer cannot write or read, so the forced
  // commit never competes with a normal TLAST commit.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    commitPtr_d = commitPtr_q;
    rdPtr_d     = rdPtr_q;
    truncErr_d  = truncErr_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + PW'(1);
      if (S0_AXIS_TLAST) begin
        commitPtr_d = wrPtr_q + PW'(1);
      end
    end
    if (forceCommit) begin
      commitPtr_d = wrPtr_q;
      truncErr_d  = 1'b1;
    end
    if (rdEn) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    level_d = wrPtr_d - rdPtr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      commitPtr_q <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      truncErr_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      commitPtr_q <= commitPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      truncErr_q  <= truncErr_d;
    end
  end

  axis_pkt_fifo_ram #(
    .ADDR_W(DEPTH_LOG2),
    .DATA_W(TDATA_W),
    .KEEP_W(TDATA_W/8)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrPtr_q[DEPTH_LOG2-1:0]),
    .wr_data_i (S0_AXIS_TDATA),
    .wr_keep_i (S0_AXIS_TKEEP),
    .wr_last_i (S0_AXIS_TLAST),
    .fix_en_i  (forceCommit),
    .fix_addr_i(fixAddr),
    .rd_addr_i (rdPtr_q[DEPTH_LOG2-1:0]),
    .rd_data_o (M0_AXIS_TDATA),
    .rd_keep_o (M0_AXIS_TKEEP),
    .rd_last_o (M0_AXIS_TLAST)
  );

  assign S0_AXIS_TREADY = !full;
  assign M0_AXIS_TVALID = rdPtr_q != commitPtr_q;
  assign level          = level_q;
  assign trunc_err      = truncErr_q;

`ifdef AXIS_PKT_FIFO_STATS_EN
  logic [31:0] statIn_q, statOut_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      statIn_q  <= '0;
      statOut_q <= '0;
    end else begin
      if ((wrEn && S0_AXIS_TLAST) || forceCommit) begin
        statIn_q <= statIn_q + 32'd1;
      end
      if (rdEn && M0_AXIS_TLAST) begin
        statOut_q <= statOut_q + 32'd1;
      end
    end
  end

  assign stat_pkts_in  = statIn_q;
  assign stat_pkts_out = statOut_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
